// File: rtl/delay_gen_pkg.sv
// rtl/delay_gen_pkg.sv - shared types and limits for the multi-channel delay/pulse generator
package delay_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } ch_state_t;

  localparam int DEF_CNT_W = 36;
  localparam int N_CH_MIN  = 1;
  localparam int N_CH_MAX  = 16;

endpackage

// File: rtl/delay_channel.sv
// rtl/delay_channel.sv - one delay/pulse channel: IDLE -> DELAY -> PULSE -> IDLE
// active reports the state the channel will hold next cycle, so the top can register busy without lag.
module delay_channel
  import delay_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_Delay,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             en,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  output logic             DL_out,
  output logic             launch_PL,
  output logic             active
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ch_state_t        state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CNT_W-1:0] d_lat, w_lat;
  logic             nxt_out, nxt_pl;
  logic             take;

  assign take   = start && en && (state == ST_IDLE) && !abort;
  assign active = (nxt_state != ST_IDLE);

  // cnt holds cycles spent in the current state (1-based), so equality with D/W marks expiry
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_out   = 1'b0;
    nxt_pl    = 1'b0;
    if (abort) begin
      nxt_state = ST_IDLE;
      nxt_cnt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            nxt_cnt = CNT_ONE;
            if (delay == '0) begin
              nxt_state = ST_PULSE;
              nxt_pl    = 1'b1;
              nxt_out   = (width != '0);
            end else begin
              nxt_state = ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          if (cnt == d_lat) begin
            nxt_state = ST_PULSE;
            nxt_cnt   = CNT_ONE;
            nxt_pl    = 1'b1;
            nxt_out   = (w_lat != '0);
          end else begin
            nxt_cnt = cnt + CNT_ONE;
          end
        end
        ST_PULSE: begin
          // a zero width still spends one silent cycle in PULSE
          if ((cnt == w_lat) || (w_lat == '0)) begin
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + CNT_ONE;
            nxt_out = 1'b1;
          end
        end
        default: begin
          nxt_state = ST_IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_Delay) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      d_lat     <= '0;
      w_lat     <= '0;
      DL_out    <= 1'b0;
      launch_PL <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      DL_out    <= nxt_out;
      launch_PL <= nxt_pl;
      if (take) begin
        d_lat <= delay;
        w_lat <= width;
      end
    end
  end

endmodule

// File: rtl/multi_delay_pulse_gen.sv
// rtl/multi_delay_pulse_gen.sv - N-channel programmable delay/pulse generator top
// Holds the launch edge detector, latched mode and busy/done aggregation over the channels.
module multi_delay_pulse_gen
  import delay_gen_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk_Delay,
  input  logic                  rst_n,
  input  logic                  DL_launch,
  input  logic                  mode,
  input  logic [N_CH-1:0]       cfg_en,
  input  logic [N_CH*CNT_W-1:0] cfg_delay,
  input  logic [N_CH*CNT_W-1:0] cfg_width,
  output logic [N_CH-1:0]       DL_out,
  output logic [N_CH-1:0]       launch_PL,
  output logic                  busy,
  output logic                  done
);

  if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
    $error("multi_delay_pulse_gen: N_CH out of range");
  end

  logic            launch_q;
  logic            mode_q;
  logic            trigger;
  logic            abort;
  logic [N_CH-1:0] ch_active;

  assign trigger = DL_launch && !launch_q && !busy;
  assign abort   = busy && !mode_q && !DL_launch;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    delay_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_Delay(clk_Delay),
      .rst_n    (rst_n),
      .start    (trigger),
      .abort    (abort),
      .en       (cfg_en[g]),
      .delay    (cfg_delay[g*CNT_W +: CNT_W]),
      .width    (cfg_width[g*CNT_W +: CNT_W]),
      .DL_out   (DL_out[g]),
      .launch_PL(launch_PL[g]),
      .active   (ch_active[g])
    );
  end

  // launch_q resets high so a level held through reset release cannot trigger
  always_ff @(posedge clk_Delay) begin
    if (!rst_n) begin
      launch_q <= 1'b1;
      mode_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      launch_q <= DL_launch;
      if (trigger) begin
        mode_q <= mode;
      end
      busy <= |ch_active;
      done <= busy && !(|ch_active) && !abort;
    end
  end

endmodule

// File: tb/tb_multi_delay_pulse_gen.sv
// tb/tb_multi_delay_pulse_gen.sv - self-checking bench for multi_delay_pulse_gen
module tb_multi_delay_pulse_gen;

  localparam int N_CH  = 4;
  localparam int CNT_W = 36;

  logic                  clk_Delay = 1'b0;
  logic                  rst_n;
  logic                  DL_launch;
  logic                  mode;
  logic [N_CH-1:0]       cfg_en;
  logic [N_CH*CNT_W-1:0] cfg_delay;
  logic [N_CH*CNT_W-1:0] cfg_width;
  logic [N_CH-1:0]       DL_out;
  logic [N_CH-1:0]       launch_PL;
  logic                  busy;
  logic                  done;

  always #5 clk_Delay = ~clk_Delay;

  multi_delay_pulse_gen #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk_Delay(clk_Delay),
    .rst_n    (rst_n),
    .DL_launch(DL_launch),
    .mode     (mode),
    .cfg_en   (cfg_en),
    .cfg_delay(cfg_delay),
    .cfg_width(cfg_width),
    .DL_out   (DL_out),
    .launch_PL(launch_PL),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [3:0]      en;
    logic [3:0][7:0] d;
    logic [3:0][7:0] w;
    logic            md;
    int              exp_done;
    int              exp_hi;
  } vec_t;

  vec_t vecs[6];

  int     n_checks = 0;
  int     n_fail   = 0;
  longint ecount   = 0;
  longint trig_edge = 0;
  int     g_hi;
  longint g_done_off;

  // Reference model: a sequence is a set of per-channel windows measured from the trigger edge
  logic            m_prev_dl = 1'b1;
  logic            m_busy = 1'b0;
  logic            m_on = 1'b0;
  logic            m_mode = 1'b0;
  longint          m_t0, m_len;
  logic [N_CH-1:0] m_en;
  longint          m_d[N_CH];
  longint          m_w[N_CH];
  logic [N_CH-1:0] exp_out = '0, exp_pl = '0;
  logic            exp_busy = 1'b0, exp_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, expv, ecount);
    end
  endtask

  task automatic model_edge();
    logic   trig, abrt;
    longint m, span;
    ecount++;
    exp_out  = '0;
    exp_pl   = '0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    if (!rst_n) begin
      m_prev_dl = 1'b1;
      m_on      = 1'b0;
      m_busy    = 1'b0;
      return;
    end
    trig = DL_launch && !m_prev_dl && !m_busy;
    abrt = m_busy && !m_mode && !DL_launch;
    m_prev_dl = DL_launch;
    if (abrt) begin
      m_on = 1'b0;
    end else if (trig) begin
      m_mode = mode;
      if (cfg_en != '0) begin
        m_on  = 1'b1;
        m_t0  = ecount;
        m_en  = cfg_en;
        m_len = 0;
        for (int i = 0; i < N_CH; i++) begin
          m_d[i] = longint'(cfg_delay[i*CNT_W +: CNT_W]);
          m_w[i] = longint'(cfg_width[i*CNT_W +: CNT_W]);
          span = m_d[i] + ((m_w[i] == 0) ? 1 : m_w[i]);
          if (m_en[i] && span > m_len) m_len = span;
        end
      end
    end
    if (m_on) begin
      m = ecount - m_t0;
      for (int i = 0; i < N_CH; i++) begin
        if (m_en[i]) begin
          exp_out[i] = (m >= m_d[i]) && (m < m_d[i] + m_w[i]);
          exp_pl[i]  = (m == m_d[i]);
        end
      end
      exp_busy = (m < m_len);
      exp_done = (m == m_len);
      if (m >= m_len) m_on = 1'b0;
    end
    m_busy = exp_busy;
  endtask

  task automatic step();
    @(posedge clk_Delay);
    #1;
    model_edge();
    chk("dl_out", 64'(DL_out), 64'(exp_out));
    chk("launch_pl", 64'(launch_PL), 64'(exp_pl));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("done", 64'(done), 64'(exp_done));
    g_hi += $countones(DL_out);
    if (done && g_done_off < 0) g_done_off = ecount - trig_edge;
  endtask

  task automatic set_ch(input int i, input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] w);
    cfg_delay[i*CNT_W +: CNT_W] = d;
    cfg_width[i*CNT_W +: CNT_W] = w;
  endtask

  task automatic fire();
    DL_launch = 1'b0;
    step();
    g_hi       = 0;
    g_done_off = -1;
    DL_launch  = 1'b1;
    trig_edge  = ecount + 1;
    step();
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && g_done_off < 0; k++) step();
  endtask

  task automatic settle();
    DL_launch = 1'b0;
    for (int k = 0; k < 40 && busy; k++) step();
    step();
  endtask

  initial begin
    vecs[0] = '{4'b1111, {8'd10, 8'd5, 8'd1, 8'd0}, {8'd4, 8'd2, 8'd3, 8'd1}, 1'b1, 14, 10};
    vecs[1] = '{4'b0010, {8'd0, 8'd0, 8'd3, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 1'b1, 4, 0};
    vecs[2] = '{4'b0101, {8'd0, 8'd7, 8'd0, 8'd2}, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b0, 8, 3};
    vecs[3] = '{4'b1000, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd6, 8'd0, 8'd0, 8'd0}, 1'b1, 6, 6};
    vecs[4] = '{4'b1001, {8'd4, 8'd0, 8'd0, 8'd4}, {8'd2, 8'd0, 8'd0, 8'd2}, 1'b0, 6, 4};
    vecs[5] = '{4'b0000, {8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b1, -1, 0};

    rst_n = 1'b0; DL_launch = 1'b0; mode = 1'b1;
    cfg_en = '0; cfg_delay = '0; cfg_width = '0;
    g_hi = 0; g_done_off = -1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      cfg_en = vecs[v].en;
      mode   = vecs[v].md;
      for (int i = 0; i < N_CH; i++) set_ch(i, CNT_W'(vecs[v].d[i]), CNT_W'(vecs[v].w[i]));
      fire();
      wait_done(40);
      chk($sformatf("vec%0d_done_at", v), 64'(g_done_off), 64'(longint'(vecs[v].exp_done)));
      chk($sformatf("vec%0d_pulse_cycles", v), 64'(g_hi), 64'(vecs[v].exp_hi));
      settle();
    end

    // gated abort mid-delay, then a clean restart
    cfg_en = 4'b0001; mode = 1'b0;
    set_ch(0, 36'd20, 36'd5);
    fire();
    repeat (7) step();
    DL_launch = 1'b0;
    step();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out", 64'({DL_out, launch_PL}), 64'd0);
    repeat (30) step();
    chk("abort_no_done", 64'(g_done_off), 64'(-64'sd1));
    set_ch(0, 36'd2, 36'd1);
    fire();
    wait_done(40);
    chk("after_abort_done_at", 64'(g_done_off), 64'd3);
    settle();

    // re-trigger edges while busy are ignored
    mode = 1'b1;
    set_ch(0, 36'd10, 36'd2);
    fire();
    repeat (2) step();
    DL_launch = 1'b0; step();
    DL_launch = 1'b1; step();
    DL_launch = 1'b0; step();
    DL_launch = 1'b1;
    wait_done(40);
    chk("retrig_done_at", 64'(g_done_off), 64'd12);
    chk("retrig_pulse_cycles", 64'(g_hi), 64'd2);
    fire();
    wait_done(40);
    chk("restart_done_at", 64'(g_done_off), 64'd12);
    settle();

    // reset mid-sequence with the launch level held high
    cfg_en = 4'b1111;
    for (int i = 0; i < N_CH; i++) set_ch(i, CNT_W'(vecs[0].d[i]), CNT_W'(vecs[0].w[i]));
    fire();
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("rst_outputs", 64'({DL_out, launch_PL, busy, done}), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rst_no_retrigger", 64'(busy), 64'd0);
    end
    DL_launch = 1'b0; step();
    DL_launch = 1'b1; step();
    chk("rst_relaunch_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 40 && busy; k++) step();
    settle();

    // full-range delay never expires early; config edits after the trigger are ignored
    cfg_en = 4'b0001; mode = 1'b0;
    set_ch(0, {CNT_W{1'b1}}, 36'd3);
    fire();
    cfg_en = 4'b1111;
    for (int i = 0; i < N_CH; i++) set_ch(i, 36'd1, 36'd1);
    repeat (50) step();
    chk("wide_still_busy", 64'(busy), 64'd1);
    chk("wide_no_pulse", 64'(g_hi), 64'd0);
    DL_launch = 1'b0;
    step();
    chk("wide_abort_busy", 64'(busy), 64'd0);
    step();
    cfg_en = 4'b0001; mode = 1'b1;
    set_ch(0, 36'd3, 36'd2);
    fire();
    set_ch(0, 36'd0, 36'd7);
    wait_done(40);
    chk("cfg_frozen_done_at", 64'(g_done_off), 64'd5);
    chk("cfg_frozen_pulse_cycles", 64'(g_hi), 64'd2);
    settle();

    // randomized traffic against the window model
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) DL_launch = ~DL_launch;
      mode   = 1'($urandom);
      cfg_en = N_CH'($urandom);
      for (int i = 0; i < N_CH; i++) set_ch(i, CNT_W'($urandom_range(0, 12)), CNT_W'($urandom_range(0, 4)));
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
